// File: rtl/sw_ctrl_pkg.sv
// Shared types and default constants for the stopwatch control front-end.
package sw_ctrl_pkg;

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_e;

    // 10 ms tick at 50 MHz.
    localparam int unsigned DefaultDiv    = 500000;
    // 20 ms of stable input before a level change is accepted.
    localparam int unsigned DefaultDebCyc = 1000000;
    // 0.5 s hold before INC auto-repeat, then 10 Hz repeat.
    localparam int unsigned DefaultRptDly = 25000000;
    localparam int unsigned DefaultRptPer = 5000000;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-level debounce counter and rising-edge press pulse
// for one raw push-button.
module btn_debounce
    import sw_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYC = DefaultDebCyc
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int unsigned    CntW   = $clog2(DEB_CYC + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYC - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            level_prev_q;
    logic            press_q;

    // Count consecutive mismatching cycles; flip the level once the run is long enough.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CntMax) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Synchronizer, debounce state and registered press pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            press_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], btn_i};
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_q & ~level_prev_q;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch control: debounces start/stop, clear and increment buttons, runs the
// STOPPED/RUNNING machine and issues single-cycle EN/INC/CLR strobes.
// Optional build macro SW_CTRL_REPEAT_EN adds INC auto-repeat while the button is held.
module sw_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int unsigned DIV     = DefaultDiv,
    parameter int unsigned DEB_CYC = DefaultDebCyc,
    parameter int unsigned RPT_DLY = DefaultRptDly,
    parameter int unsigned RPT_PER = DefaultRptPer
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_SS,
    input  logic BTN_CLR,
    input  logic BTN_INC,
    output logic EN,
    output logic INC,
    output logic CLR,
    output logic RUN
);

    localparam int unsigned    PreW   = $clog2(DIV + 1);
    localparam logic [PreW-1:0] PreMax = PreW'(DIV - 1);

    logic ss_press, clr_press, inc_press;
    logic ss_lvl, clr_lvl, inc_lvl;
    logic rpt_fire;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ss (
        .clk_i  (CLK),
        .rst_i  (RST),
        .btn_i  (BTN_SS),
        .level_o(ss_lvl),
        .press_o(ss_press)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_clr (
        .clk_i  (CLK),
        .rst_i  (RST),
        .btn_i  (BTN_CLR),
        .level_o(clr_lvl),
        .press_o(clr_press)
    );

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
        .clk_i  (CLK),
        .rst_i  (RST),
        .btn_i  (BTN_INC),
        .level_o(inc_lvl),
        .press_o(inc_press)
    );

    state_e          state_q, state_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic            en_q, en_d;
    logic            inc_q, inc_d;
    logic            clr_q, clr_d;

`ifdef SW_CTRL_REPEAT_EN
    localparam int unsigned    RptMax = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int unsigned    RptW   = $clog2(RptMax + 1);
    localparam logic [RptW-1:0] DlyMax = RptW'(RPT_DLY - 1);
    localparam logic [RptW-1:0] PerMax = RptW'(RPT_PER - 1);

    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            rpt_arm_q, rpt_arm_d;
    logic            rpt_per_q, rpt_per_d;

    // Repeat timer: armed by an accepted INC press, first gap RPT_DLY, then RPT_PER.
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        rpt_arm_d = rpt_arm_q;
        rpt_per_d = rpt_per_q;
        rpt_fire  = 1'b0;
        if (state_q != STOPPED || !inc_lvl) begin
            rpt_cnt_d = '0;
            rpt_arm_d = 1'b0;
            rpt_per_d = 1'b0;
        end else if (inc_press && !ss_press && !clr_press) begin
            rpt_cnt_d = '0;
            rpt_arm_d = 1'b1;
            rpt_per_d = 1'b0;
        end else if (rpt_arm_q) begin
            if (rpt_cnt_q == (rpt_per_q ? PerMax : DlyMax)) begin
                rpt_fire  = 1'b1;
                rpt_cnt_d = '0;
                rpt_per_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + RptW'(1);
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rpt_cnt_q <= '0;
            rpt_arm_q <= 1'b0;
            rpt_per_q <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_arm_q <= rpt_arm_d;
            rpt_per_q <= rpt_per_d;
        end
    end

    logic unused_lvl;
    assign unused_lvl = ss_lvl ^ clr_lvl;
`else
    assign rpt_fire = 1'b0;

    // Levels and repeat timing only matter to the auto-repeat build.
    logic unused_sig;
    assign unused_sig = ^{ss_lvl, clr_lvl, inc_lvl, RPT_DLY[0], RPT_PER[0]};
`endif

    // Run/stop decisions with ss > clr > inc priority, prescaler and strobe generation.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        en_d    = 1'b0;
        inc_d   = 1'b0;
        clr_d   = 1'b0;
        unique case (state_q)
            STOPPED: begin
                if (ss_press) begin
                    state_d = RUNNING;
                    presc_d = '0;
                end else if (clr_press) begin
                    clr_d = 1'b1;
                end else if (inc_press || rpt_fire) begin
                    inc_d = 1'b1;
                end
            end
            RUNNING: begin
                // A stop press wins over a tick due in the same cycle.
                if (ss_press) begin
                    state_d = STOPPED;
                end else if (presc_q == PreMax) begin
                    en_d    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PreW'(1);
                end
            end
            default: state_d = STOPPED;
        endcase
    end

    // State, prescaler and output strobe registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= STOPPED;
            presc_q <= '0;
            en_q    <= 1'b0;
            inc_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            en_q    <= en_d;
            inc_q   <= inc_d;
            clr_q   <= clr_d;
        end
    end

    assign EN  = en_q;
    assign INC = inc_q;
    assign CLR = clr_q;
    assign RUN = (state_q == RUNNING);

endmodule

// File: tb/tb_sw_ctrl.sv
// Directed bench for sw_ctrl with a strobe scoreboard (DIV=4, DEB_CYC=3, RPT_DLY=10, RPT_PER=4).
module tb_sw_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic BTN_SS = 1'b0;
    logic BTN_CLR = 1'b0;
    logic BTN_INC = 1'b0;
    logic EN, INC, CLR, RUN;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;

    typedef struct {
        int         cyc;
        logic [2:0] s;     // {EN, INC, CLR}
    } ev_t;

    ev_t exp_q[$];

    localparam logic [2:0] SEn  = 3'b100;
    localparam logic [2:0] SInc = 3'b010;
    localparam logic [2:0] SClr = 3'b001;

    sw_ctrl #(
        .DIV    (4),
        .DEB_CYC(3),
        .RPT_DLY(10),
        .RPT_PER(4)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .BTN_SS (BTN_SS),
        .BTN_CLR(BTN_CLR),
        .BTN_INC(BTN_INC),
        .EN     (EN),
        .INC    (INC),
        .CLR    (CLR),
        .RUN    (RUN)
    );

    initial forever #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input logic [2:0] s);
        ev_t e;
        e.cyc = c;
        e.s   = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    // Scoreboard: every cycle either an expected strobe is due or all strobes must be low.
    always @(negedge CLK) begin
        if (mon_on) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("strobe_missed", 32'(3'b000), 32'(exp_q[0].s));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                check("strobe", 32'({EN, INC, CLR}), 32'(exp_q[0].s));
                void'(exp_q.pop_front());
            end else if ({EN, INC, CLR} !== 3'b000) begin
                check("unexpected_strobe", 32'({EN, INC, CLR}), 32'(3'b000));
            end
        end
    end

    initial begin
        int k;
        int kk;
        int m;

        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst_run", 32'(RUN), 0);
        check("rst_en",  32'(EN),  0);
        check("rst_inc", 32'(INC), 0);
        check("rst_clr", 32'(CLR), 0);
        mon_on = 1'b1;

        // 1: start with BTN_SS held from reset release; EN every 4 cycles.
        RST    = 1'b0;
        BTN_SS = 1'b1;
        k = cyc + 1;
        // Stop press lands at k+46, exactly when a tick would be due: that EN is suppressed.
        for (int c = k + 10; c < k + 46; c += 4) push_ev(c, SEn);
        wait_until(k + 5);
        check("t1_run_before", 32'(RUN), 0);
        wait_until(k + 6);
        check("t1_run_after", 32'(RUN), 1);
        wait_until(k + 10);
        BTN_SS = 1'b0;

        // 3: INC and CLR while running are ignored, then stop.
        wait_until(k + 14);
        BTN_INC = 1'b1;
        BTN_CLR = 1'b1;
        wait_until(k + 24);
        BTN_INC = 1'b0;
        BTN_CLR = 1'b0;
        wait_until(k + 39);
        BTN_SS = 1'b1;
        wait_until(k + 45);
        check("t3_run_before_stop", 32'(RUN), 1);
        wait_until(k + 46);
        check("t3_run_after_stop", 32'(RUN), 0);
        wait_until(k + 50);
        BTN_SS = 1'b0;
        wait_until(k + 60);
        check("t3_queue_drained", 32'(exp_q.size()), 0);

        // 2: a 2-cycle glitch on CLR is rejected; a held press gives one CLR.
        BTN_CLR = 1'b1;
        repeat (2) @(negedge CLK);
        BTN_CLR = 1'b0;
        repeat (8) @(negedge CLK);
        BTN_CLR = 1'b1;
        k = cyc + 1;
        push_ev(k + 6, SClr);
        wait_until(k + 8);
        BTN_CLR = 1'b0;
        wait_until(k + 16);
        check("t2_run_low", 32'(RUN), 0);

        // 4: simultaneous rise on all three buttons; only start/stop acts.
        BTN_SS  = 1'b1;
        BTN_CLR = 1'b1;
        BTN_INC = 1'b1;
        k = cyc + 1;
        for (int c = k + 10; c < k + 26; c += 4) push_ev(c, SEn);
        wait_until(k + 5);
        check("t4_run_before", 32'(RUN), 0);
        wait_until(k + 6);
        check("t4_run_after", 32'(RUN), 1);
        wait_until(k + 10);
        BTN_SS  = 1'b0;
        BTN_CLR = 1'b0;
        BTN_INC = 1'b0;
        wait_until(k + 19);
        BTN_SS = 1'b1;
        wait_until(k + 25);
        check("t4_run_before_stop", 32'(RUN), 1);
        wait_until(k + 26);
        check("t4_run_after_stop", 32'(RUN), 0);
        wait_until(k + 30);
        BTN_SS = 1'b0;
        wait_until(k + 40);

        // 5: reset while running with BTN_SS held; restart after release.
        BTN_SS = 1'b1;
        k = cyc + 1;
        push_ev(k + 10, SEn);
        push_ev(k + 14, SEn);
        wait_until(k + 6);
        check("t5_run", 32'(RUN), 1);
        wait_until(k + 15);
        RST = 1'b1;
        wait_until(k + 16);
        check("t5_rst_run", 32'(RUN), 0);
        check("t5_rst_en",  32'(EN),  0);
        check("t5_rst_inc", 32'(INC), 0);
        check("t5_rst_clr", 32'(CLR), 0);
        wait_until(k + 17);
        RST = 1'b0;
        kk = k + 18;
        push_ev(kk + 10, SEn);
        push_ev(kk + 14, SEn);
        wait_until(kk + 5);
        check("t5_rerun_before", 32'(RUN), 0);
        wait_until(kk + 6);
        check("t5_rerun_after", 32'(RUN), 1);
        wait_until(kk + 15);
        RST    = 1'b1;
        BTN_SS = 1'b0;
        wait_until(kk + 17);
        RST = 1'b0;
        wait_until(kk + 25);
        check("t5_stopped", 32'(RUN), 0);

        // 6: hold BTN_INC for 30 cycles while stopped.
        m = cyc;
        BTN_INC = 1'b1;
        k = m + 1;
        push_ev(k + 6, SInc);
`ifdef SW_CTRL_REPEAT_EN
        // Level falls at k+34, so repeats at +10 then every 4 up to k+32.
        for (int c = k + 16; c <= k + 32; c += 4) push_ev(c, SInc);
`endif
        wait_until(m + 30);
        BTN_INC = 1'b0;
        wait_until(k + 45);
        check("t6_run_low", 32'(RUN), 0);

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sw_ctrl.md
Name: sw_ctrl

Overview:
- Control front-end for the stopwatch. It sits directly upstream of the BCD 00-99 centisecond/second counter chain.
- Debounces three raw push-buttons (start/stop, clear, manual increment) and runs a run/stop state machine.
- Produces the single-cycle EN (time-base tick), INC (manual step) and CLR strobes that the counter stage consumes.

Parameters:
- DIV, 500000: CLK cycles per EN tick (10 ms at 50 MHz); legal range >= 2.
- DEB_CYC, 1000000: consecutive stable synchronized cycles needed to accept a button level change; legal range >= 1.
- RPT_DLY, 25000000: hold time before INC auto-repeat starts, in cycles (used only with the optional feature).
- RPT_PER, 5000000: auto-repeat period in cycles (used only with the optional feature).

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- BTN_SS  in  1  raw start/stop button, asynchronous, active-high
- BTN_CLR  in  1  raw clear button, asynchronous, active-high
- BTN_INC  in  1  raw manual-increment button, asynchronous, active-high
- EN  out  1  one-cycle time-base tick, only while running
- INC  out  1  one-cycle manual increment strobe
- CLR  out  1  one-cycle clear strobe
- RUN  out  1  high in RUNNING state

Behaviour:
- Reset: RST is synchronous, active-high; clock is CLK. On reset: EN=INC=CLR=RUN=0, state=STOPPED, prescaler=0, all debounce counters=0, sync flops=0, debounced levels=0.
- Reset mid-operation: RST aborts all activity with no strobes emitted. A button held through reset is seen as a new press once DEB_CYC stable cycles have elapsed after reset release.
- Synchronizer: each raw button passes through 2 flip-flops.
- Debounce, per button:
  - While the synchronized level differs from the debounced level, the counter increments; otherwise the counter clears.
  - When the counter reaches DEB_CYC-1 with a mismatch still present, the debounced level flips and the counter clears.
  - A rising debounced edge yields a 1-cycle press pulse. Falling edges produce nothing.
- Latency: raw rise stable before CLK edge k -> press pulse internal at k+DEB_CYC+2 -> registered output strobe (or state change) at k+DEB_CYC+3.
- FSM states: STOPPED, RUNNING.
  - STOPPED + ss press -> RUNNING, prescaler cleared to 0.
  - RUNNING + ss press -> STOPPED, prescaler held.
  - STOPPED + clr press -> CLR=1 for 1 cycle.
  - STOPPED + inc press -> INC=1 for 1 cycle.
  - RUNNING: clr and inc presses are ignored (discarded, not queued).
- Simultaneous presses in the same cycle: priority is ss > clr > inc; lower-priority presses that cycle are dropped.
- Prescaler: counts 0..DIV-1 only in RUNNING and wraps to 0. EN=1 in the cycle after the count equals DIV-1.
  - First EN arrives exactly DIV cycles after RUN rises.
  - Leaving RUNNING on the cycle a tick is due suppresses that EN.
- Exclusivity: EN, INC and CLR are never high together; INC and CLR are only possible while RUN=0.
- Widths: counters use $clog2(param+1) bits, no overflow possible.

Optional Feature:
- Macro SW_CTRL_REPEAT_EN.
- Defined: in STOPPED, with debounced INC held, INC pulses once at press, again after RPT_DLY cycles, then every RPT_PER cycles. Release or leaving STOPPED cancels the repeat and resets the repeat counter.
- Undefined: exactly one INC per press; RPT_DLY and RPT_PER are unused and the repeat logic is absent.

Decomposition:
- Package sw_ctrl_pkg:
  - state typedef {STOPPED, RUNNING}
  - default constants for DIV, DEB_CYC, RPT_DLY, RPT_PER
- One natural sub-module: btn_debounce (synchronizer + debounce counter + rise-pulse), parameterized by DEB_CYC and instantiated 3 times.

Test Plan (DIV=4, DEB_CYC=3, RPT_DLY=10, RPT_PER=4):
1. Reset, then hold BTN_SS high from cycle 0 -> RUN=1 at cycle 6; EN pulses at cycles 10, 14, 18; no INC/CLR.
2. 2-cycle glitch on BTN_CLR -> no CLR, debounced level unchanged. Then a held press while STOPPED -> one CLR pulse 6 cycles later.
3. While RUNNING, press BTN_INC and BTN_CLR -> no INC/CLR. Then press BTN_SS -> RUN=0 and EN stops with no further ticks.
4. Same cycle raw rise on BTN_SS, BTN_CLR, BTN_INC while STOPPED -> RUN=1 only; no CLR/INC emitted.
5. Assert RST during RUNNING with BTN_SS held -> all outputs 0 next cycle; RUN=1 again at 6 cycles after RST release.
6. With SW_CTRL_REPEAT_EN, hold BTN_INC 30 cycles while STOPPED -> INC at press, +10, then every 4 cycles until release. Without the macro -> a single INC.
